// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } fetch_state_e;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    // Instruction addresses are word aligned; the two byte-offset bits are forced to zero.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Refill handshake between the fetch stage (master) and instruction memory (slave).
interface mips_fetch_if;
    import mips_fetch_pkg::*;

    logic            MemReadRequest;
    logic [XLEN-1:0] MemAddressOutput;
    logic [XLEN-1:0] MemDataInput;
    logic            MemReadyInput;

    modport master (
        output MemReadRequest,
        output MemAddressOutput,
        input  MemDataInput,
        input  MemReadyInput
    );

    modport slave (
        input  MemReadRequest,
        input  MemAddressOutput,
        output MemDataInput,
        output MemReadyInput
    );

endinterface

// File: rtl/mips_icache_array.sv
// Direct-mapped one-word-per-line instruction cache storage.
// Combinational read port, synchronous write port, synchronous clear of all valid bits.
module mips_icache_array
    import mips_fetch_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned TAG_BITS   = 26
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [XLEN-1:0]       rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [XLEN-1:0]       wr_data_i
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [XLEN-1:0]     data_q [LINES];

    // Only the valid bits need clearing; stale tag/data behind a clear bit is never observed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i && !rst_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC register, I-cache lookup, miss refill FSM and IF/ID outputs.
// Hit/instruction/next-PC are combinational from the PC register and the cache array.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic             ClockPulse,
    input  logic             Reset,
    input  logic             StallInput,
    input  logic             BranchTakenInput,
    input  logic [XLEN-1:0]  BranchTargetInput,
    mips_fetch_if.master     mem,
    output logic [XLEN-1:0]  NextPcOutput,
    output logic [XLEN-1:0]  InstructionOutput,
    output logic             HitOutput
);

    localparam int unsigned TAG_BITS = XLEN - INDEX_BITS - 2;

    fetch_state_e          state_q;
    logic [XLEN-1:0]       pc_q;
    logic                  pend_valid_q;
    logic [XLEN-1:0]       pend_target_q;

    logic [INDEX_BITS-1:0] idx_c;
    logic [TAG_BITS-1:0]   tag_c;
    logic                  line_valid_c;
    logic [TAG_BITS-1:0]   line_tag_c;
    logic [XLEN-1:0]       line_data_c;
    logic                  hit_c;
    logic                  refill_done_c;
    logic [XLEN-1:0]       branch_target_c;
    logic [XLEN-1:0]       pc_inc_c;

    assign idx_c           = pc_q[INDEX_BITS+1:2];
    assign tag_c           = pc_q[XLEN-1:INDEX_BITS+2];
    assign hit_c           = (state_q == LOOKUP) && line_valid_c && (line_tag_c == tag_c);
    assign refill_done_c   = (state_q == REFILL) && mem.MemReadyInput;
    assign branch_target_c = word_align(BranchTargetInput);
    assign pc_inc_c        = pc_q + PC_STEP;

    mips_icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_icache (
        .clk_i      (ClockPulse),
        .rst_i      (Reset),
        .rd_idx_i   (idx_c),
        .rd_valid_o (line_valid_c),
        .rd_tag_o   (line_tag_c),
        .rd_data_o  (line_data_c),
        .we_i       (refill_done_c),
        .wr_idx_i   (idx_c),
        .wr_tag_i   (tag_c),
        .wr_data_i  (mem.MemDataInput)
    );

    // PC / refill FSM; priority Reset > branch > stall > increment.
    always_ff @(posedge ClockPulse) begin
        if (Reset) begin
            state_q       <= LOOKUP;
            pc_q          <= word_align(RESET_PC);
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            case (state_q)
                LOOKUP: begin
                    if (BranchTakenInput) begin
                        // A miss on a redirected (dead) path is dropped without refilling.
                        pc_q <= branch_target_c;
                    end else if (!hit_c) begin
                        state_q <= REFILL;
                    end else if (!StallInput) begin
                        pc_q <= pc_inc_c;
                    end
                end
                REFILL: begin
                    if (mem.MemReadyInput) begin
                        state_q      <= LOOKUP;
                        pend_valid_q <= 1'b0;
                        if (BranchTakenInput) begin
                            pc_q <= branch_target_c;
                        end else if (pend_valid_q) begin
                            pc_q <= pend_target_q;
                        end
                    end else if (BranchTakenInput) begin
                        // Redirects during refill are deferred; the latest one wins.
                        pend_valid_q  <= 1'b1;
                        pend_target_q <= branch_target_c;
                    end
                end
                default: begin
                    state_q <= LOOKUP;
                end
            endcase
        end
    end

    assign mem.MemReadRequest   = (state_q == REFILL);
    assign mem.MemAddressOutput = pc_q;

    assign HitOutput         = hit_c;
    assign NextPcOutput      = pc_inc_c;
    assign InstructionOutput = hit_c ? line_data_c : NOP_INSTR;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios then randomized traffic,
// all compared against a behavioural fetch model built on an address-keyed line table.
module tb_mips_fetch_unit;
    import mips_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          LINES    = 16;

    logic        clk = 1'b0;
    logic        rst, st, br, rdy;
    logic [31:0] tgt;
    logic [31:0] npc, instr;
    logic        hit;

    mips_fetch_if mif ();

    // Memory returns word = address | 1.
    assign mif.MemDataInput  = mif.MemAddressOutput | 32'h1;
    assign mif.MemReadyInput = rdy;

    mips_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .INDEX_BITS (4)
    ) dut (
        .ClockPulse        (clk),
        .Reset             (rst),
        .StallInput        (st),
        .BranchTakenInput  (br),
        .BranchTargetInput (tgt),
        .mem               (mif.master),
        .NextPcOutput      (npc),
        .InstructionOutput (instr),
        .HitOutput         (hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the cache is a table of "which word address lives in line i".
    logic [31:0] m_pc;
    bit          m_refill;
    bit          m_pend_v;
    logic [31:0] m_pend_t;
    logic [31:0] m_line [int];
    int          wcnt;
    int          mem_lat = 2;
    int          rdy_ovr = -1;

    logic        last_hit, last_req;
    logic [31:0] last_npc, last_instr, last_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % LINES);
    endfunction

    function automatic bit model_hit();
        int i;
        i = line_of(m_pc);
        return !m_refill && m_line.exists(i) && (m_line[i] == m_pc);
    endfunction

    task automatic step(input bit r, input bit b, input logic [31:0] t, input bit s);
        bit          h;
        bit          rv;
        logic [31:0] ta;
        @(negedge clk);
        h          = model_hit();
        last_hit   = hit;
        last_req   = mif.MemReadRequest;
        last_npc   = npc;
        last_instr = instr;
        last_addr  = mif.MemAddressOutput;
        chk("hit", 32'(hit), 32'(h));
        chk("next_pc", npc, m_pc + 32'd4);
        chk("instr", instr, h ? (m_pc | 32'h1) : 32'h0);
        chk("mem_req", 32'(mif.MemReadRequest), 32'(m_refill));
        if (m_refill) chk("mem_addr", mif.MemAddressOutput, m_pc);
        if (rdy_ovr >= 0) rv = (rdy_ovr != 0);
        else if (m_refill) rv = (wcnt >= mem_lat - 1);
        else rv = ($urandom_range(3) == 0);
        rst = r; br = b; tgt = t; st = s; rdy = rv;
        ta = t & 32'hFFFF_FFFC;
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_line.delete(); m_refill = 0; m_pend_v = 0;
        end else if (!m_refill) begin
            if (b) m_pc = ta;
            else if (!h) begin m_refill = 1; wcnt = 0; end
            else if (!s) m_pc = m_pc + 32'd4;
        end else if (rv) begin
            m_line[line_of(m_pc)] = m_pc;
            m_refill = 0;
            if (b) m_pc = ta;
            else if (m_pend_v) m_pc = m_pend_t;
            m_pend_v = 0;
        end else begin
            wcnt++;
            if (b) begin m_pend_v = 1; m_pend_t = ta; end
        end
    endtask

    initial begin
        int hits2, reqs2, guard;
        rst = 1'b1; st = 1'b0; br = 1'b0; rdy = 1'b0; tgt = '0;
        repeat (2) @(posedge clk);
        m_pc = RESET_PC; m_refill = 0; m_pend_v = 0; wcnt = 0;

        // 1: cold miss at reset PC, two-cycle memory
        mem_lat = 2;
        step(0, 0, 0, 0);
        chk("t1_reset_hit", 32'(last_hit), 32'h0);
        step(0, 0, 0, 0);
        chk("t1_req", 32'(last_req), 32'h1);
        chk("t1_addr", last_addr, 32'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t1_hit", 32'(last_hit), 32'h1);
        chk("t1_instr", last_instr, 32'h1);
        chk("t1_npc", last_npc, 32'h4);

        // 2: fill 0..60, then replay from the cache
        guard = 0;
        while (m_pc != 32'd64 && guard < 200) begin step(0, 0, 0, 0); guard++; end
        chk("t2_fill_done", m_pc, 32'd64);
        step(0, 1, 32'h0, 0);
        hits2 = 0; reqs2 = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0);
            hits2 += int'(last_hit);
            reqs2 += int'(last_req);
        end
        chk("t2_hits", 32'(hits2), 32'd16);
        chk("t2_reqs", 32'(reqs2), 32'd0);
        chk("t2_last_npc", last_npc, 32'd64);

        // 3: 0x40 evicts 0x00, which then misses again
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 32'h0, 0);
        chk("t3_hit_0x40", 32'(last_hit), 32'h1);
        step(0, 0, 0, 0);
        chk("t3_conflict_miss", 32'(last_hit), 32'h0);
        repeat (2) step(0, 0, 0, 0);

        // 4: stall three cycles on a hit at PC=8
        step(0, 1, 32'h8, 0);
        repeat (3) begin
            step(0, 0, 0, 1);
            chk("t4_stall_npc", last_npc, 32'd12);
            chk("t4_stall_instr", last_instr, 32'h9);
        end

        // 5: redirect during refill of 0x20, then branch+stall
        mem_lat = 3;
        step(1, 0, 0, 0);
        step(0, 1, 32'h23, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h100, 0);
        chk("t5_refill_req", 32'(last_req), 32'h1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h20, 1);
        chk("t5_after_refill_npc", last_npc, 32'h104);
        step(0, 1, 32'h40, 1);
        chk("t5_line8_hit", 32'(last_hit), 32'h1);
        chk("t5_line8_instr", last_instr, 32'h21);
        step(0, 0, 0, 0);
        chk("t5_branch_over_stall", last_npc, 32'h44);

        // 6: reset with ready on the same edge mid-refill, then PC wrap
        mem_lat = 2;
        step(0, 0, 0, 0);
        chk("t6_in_refill", 32'(last_req), 32'h1);
        rdy_ovr = 1;
        step(1, 0, 0, 0);
        rdy_ovr = -1;
        step(0, 1, 32'h40, 0);
        chk("t6_req_dropped", 32'(last_req), 32'h0);
        chk("t6_reset_npc", last_npc, 32'h4);
        step(0, 1, 32'hFFFF_FFFC, 0);
        chk("t6_no_line_written", 32'(last_hit), 32'h0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t6_wrap_hit", 32'(last_hit), 32'h1);
        chk("t6_wrap_npc", last_npc, 32'h0);
        step(0, 0, 0, 0);
        chk("t6_wrapped_pc_npc", last_npc, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit          r, b, s;
            logic [31:0] t;
            if (!m_refill) mem_lat = $urandom_range(1, 4);
            r = ($urandom_range(99) == 0);
            b = ($urandom_range(9) == 0);
            s = ($urandom_range(4) == 0);
            t = ($urandom_range(3) == 0) ? 32'($urandom) : (32'($urandom_range(255)) << 2);
            step(r, b, t, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
